// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns memory-stage load/store requests into
// word-aligned Avalon-MM transactions, extends load data and stalls the
// pipeline until the access completes, is dropped as misaligned, or times out.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access in flight; a new request is decoded here
// WR_REQ  | bus_write asserted, waiting for the slave to drop waitrequest
// RD_REQ  | bus_read asserted, waiting for the slave to drop waitrequest
// RD_WAIT | read accepted, waiting for readdatavalid
// DONE    | stall released for one cycle so the pipeline advances
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] bus_addr,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  input  logic        bus_readdatavalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Last counter value before abort; the counter starts at 0 on the first
  // bus-wait cycle, so TIMEOUT_CYCLES cycles are spent waiting in total.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        req_any, is_byte, is_half, req_misal, tmo, busy;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Width decode: funct3[1:0]=00 byte, 01 half, anything else is a word.
  assign req_any   = req_read | req_write;
  assign is_byte   = (req_type[1:0] == 2'b00);
  assign is_half   = (req_type[1:0] == 2'b01);
  assign req_misal = is_half ? req_addr[0] : (!is_byte && (req_addr[1:0] != 2'b00));
  assign tmo       = (cnt_q == TMO_LAST);
  assign busy      = (state_q == WR_REQ) || (state_q == RD_REQ) || (state_q == RD_WAIT);

  // Lane selection and extension of the returned read word.
  assign byte_sel = bus_readdata[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? bus_readdata[31:16] : bus_readdata[15:0];
  always_comb begin
    load_ext = bus_readdata;
    if (type_q[1:0] == 2'b00) begin
      load_ext = {{24{byte_sel[7] & ~type_q[2]}}, byte_sel};
    end else if (type_q[1:0] == 2'b01) begin
      load_ext = {{16{half_sel[15] & ~type_q[2]}}, half_sel};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a normal completion wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (req_misal)      state_d = DONE;
          else if (req_write) state_d = WR_REQ;
          else                state_d = RD_REQ;
        end
      end
      WR_REQ:  if (!bus_waitrequest || tmo) state_d = DONE;
      RD_REQ: begin
        if (!bus_waitrequest) state_d = RD_WAIT;
        else if (tmo)         state_d = DONE;
      end
      RD_WAIT: if (bus_readdatavalid || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus, result and pulse registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      be_q        <= '0;
      type_q      <= '0;
      off_q       <= '0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      be_q        <= be_d;
      type_q      <= type_d;
      off_q       <= off_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Output/datapath update: load the bus request, drop it on accept or abort.
  always_comb begin
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    be_d        = be_q;
    type_d      = type_q;
    off_d       = off_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (req_misal) begin
            misalign_d = 1'b1;
            if (!req_write) rdata_d = '0;
          end else begin
            cnt_d       = '0;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            type_d      = req_type;
            off_d       = req_addr[1:0];
            bus_write_d = req_write;
            bus_read_d  = ~req_write;
            if (is_byte) begin
              be_d    = 4'b0001 << req_addr[1:0];
              wdata_d = {4{req_wdata[7:0]}};
            end else if (is_half) begin
              be_d    = 4'b0011 << {req_addr[1], 1'b0};
              wdata_d = {2{req_wdata[15:0]}};
            end else begin
              be_d    = 4'b1111;
              wdata_d = req_wdata;
            end
          end
        end
      end
      WR_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (!bus_waitrequest) begin
          bus_write_d = 1'b0;
        end else if (tmo) begin
          bus_write_d = 1'b0;
          bus_err_d   = 1'b1;
        end
      end
      RD_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (!bus_waitrequest) begin
          bus_read_d = 1'b0;
        end else if (tmo) begin
          bus_read_d = 1'b0;
          bus_err_d  = 1'b1;
          rdata_d    = '0;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_readdatavalid) begin
          rdata_d = load_ext;
        end else if (tmo) begin
          bus_err_d = 1'b1;
          rdata_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Stall is forced low during reset so every output reads 0 there.
  assign stall          = rst_n & (busy | ((state_q == IDLE) & req_any));
  assign rdata          = rdata_q;
  assign misalign       = misalign_q;
  assign bus_err        = bus_err_q;
  assign bus_addr       = bus_addr_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign bus_byteenable = be_q;
  assign bus_writedata  = wdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Testbench for dmem_bus_ctrl: a cycle-driven slave model plus an
// arithmetic reference for byte enables, store replication and load extension.
module tb_dmem_bus_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read, req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        stall, misalign, bus_err, bus_read, bus_write;
  logic [31:0] rdata, bus_addr, bus_writedata, bus_readdata;
  logic [3:0]  bus_byteenable;
  logic        bus_waitrequest, bus_readdatavalid;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_rdata;

  int          obs_stall_n, obs_rd_n, obs_wr_n;
  bit          obs_hung, obs_unstable;
  logic        obs_misalign, obs_err, obs_done_bus;
  logic [31:0] obs_addr, obs_wd, obs_rdata;
  logic [3:0]  obs_be;
  logic [2:0]  obs_after;

  always #5 clk = ~clk;

  dmem_bus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_type          (req_type),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .stall             (stall),
    .rdata             (rdata),
    .misalign          (misalign),
    .bus_err           (bus_err),
    .bus_addr          (bus_addr),
    .bus_read          (bus_read),
    .bus_write         (bus_write),
    .bus_byteenable    (bus_byteenable),
    .bus_writedata     (bus_writedata),
    .bus_waitrequest   (bus_waitrequest),
    .bus_readdata      (bus_readdata),
    .bus_readdatavalid (bus_readdatavalid)
  );

  // Reference model: access size in bytes from funct3.
  function automatic int ref_size(input logic [2:0] t);
    if (t == 3'b000 || t == 3'b100) return 1;
    if (t == 3'b001 || t == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit ref_misal(input logic [2:0] t, input logic [31:0] a);
    return (int'(a[1:0]) % ref_size(t)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] t, input logic [31:0] a);
    int be;
    be = ((1 << ref_size(t)) - 1) << int'(a[1:0]);
    return be[3:0];
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] t, input logic [31:0] d);
    int sz;
    sz = ref_size(t);
    if (sz == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] w);
    int sz;
    logic [31:0] v, mask;
    sz = ref_size(t);
    if (sz == 4) return w;
    mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (w >> (8 * int'(a[1:0]))) & mask;
    if (!t[2] && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  // Drives one request and plays the slave; records what the DUT did.
  task automatic run_access(input bit wr, input bit rd, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int wait_n, input int rdv_dly, input logic [31:0] word);
    int seen, post;
    bit accepted;
    obs_stall_n = 0; obs_rd_n = 0; obs_wr_n = 0;
    obs_hung = 1; obs_unstable = 0;
    obs_addr = '0; obs_be = '0; obs_wd = '0;
    seen = 0; post = 0; accepted = 0;
    @(negedge clk);
    req_write = wr; req_read = rd; req_type = t; req_addr = a; req_wdata = wd;
    bus_waitrequest = 1'b0; bus_readdatavalid = 1'b0; bus_readdata = $urandom;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (stall !== 1'b1) begin
        obs_hung = 0;
        break;
      end
      obs_stall_n++;
      if (bus_read || bus_write) begin
        if (seen == 0) begin
          obs_addr = bus_addr; obs_be = bus_byteenable; obs_wd = bus_writedata;
        end else if (bus_addr !== obs_addr || bus_byteenable !== obs_be ||
                     bus_writedata !== obs_wd) begin
          obs_unstable = 1;
        end
        if (bus_read)  obs_rd_n++;
        if (bus_write) obs_wr_n++;
        if (bus_read && bus_write) obs_unstable = 1;
        seen++;
        bus_waitrequest = (seen <= wait_n);
        if (!bus_waitrequest && bus_read) accepted = 1;
        bus_readdatavalid = 1'b0;
        bus_readdata = $urandom;
      end else begin
        bus_waitrequest = 1'b0;
        if (accepted) post++;
        bus_readdatavalid = accepted && (post == rdv_dly);
        bus_readdata = bus_readdatavalid ? word : $urandom;
      end
      @(negedge clk);
    end
    obs_misalign = misalign; obs_err = bus_err; obs_rdata = rdata;
    obs_done_bus = bus_read | bus_write;
    req_write = 1'b0; req_read = 1'b0;
    bus_readdatavalid = 1'b0; bus_waitrequest = 1'b0;
    @(negedge clk);
    #1;
    obs_after = {misalign, bus_err, stall};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_read = 1'b1; req_write = 1'b1; req_type = 3'b010;
    req_addr = 32'h0000_0100; req_wdata = 32'h1234_5678;
    bus_waitrequest = 1'b0; bus_readdatavalid = 1'b1; bus_readdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({stall, bus_read, bus_write, misalign, bus_err, bus_byteenable,
         bus_addr, bus_writedata, rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got stall=%b rd=%b wr=%b mis=%b err=%b be=%h addr=%h wd=%h rdata=%h exp all 0",
               stall, bus_read, bus_write, misalign, bus_err, bus_byteenable,
               bus_addr, bus_writedata, rdata);
    end
    req_read = 1'b0; req_write = 1'b0; bus_readdatavalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = '0;
  endtask

  task automatic test_store();
    run_access(1, 0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1, 0);
    total++; if (obs_hung !== 0 || obs_stall_n !== 2) begin bad++;
      $display("FAIL sw_stall got=%0d hung=%0d exp=2", obs_stall_n, obs_hung); end
    total++; if (obs_wr_n !== 1 || obs_rd_n !== 0) begin bad++;
      $display("FAIL sw_bus_cycles got wr=%0d rd=%0d exp wr=1 rd=0", obs_wr_n, obs_rd_n); end
    total++; if ({obs_addr, obs_be, obs_wd} !== {32'h0000_0100, 4'hF, 32'hDEAD_BEEF}) begin bad++;
      $display("FAIL sw_bus got addr=%h be=%h wd=%h exp 00000100 f deadbeef", obs_addr, obs_be, obs_wd); end
    total++; if ({obs_misalign, obs_err, obs_done_bus} !== 3'b000 || obs_rdata !== model_rdata) begin bad++;
      $display("FAIL sw_done got mis=%b err=%b bus=%b rdata=%h exp 0 0 0 %h",
               obs_misalign, obs_err, obs_done_bus, obs_rdata, model_rdata); end

    run_access(1, 0, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 1, 0);
    total++; if ({obs_addr, obs_be, obs_wd} !== {32'h0000_0200, 4'b1000, 32'hA5A5_A5A5}) begin bad++;
      $display("FAIL sb_bus got addr=%h be=%b wd=%h exp 00000200 1000 a5a5a5a5", obs_addr, obs_be, obs_wd); end

    run_access(1, 0, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 3, 1, 0);
    total++; if (obs_stall_n !== 5 || obs_wr_n !== 4 || obs_unstable !== 0) begin bad++;
      $display("FAIL sh_wait got stall=%0d wr=%0d unstable=%0d exp 5 4 0", obs_stall_n, obs_wr_n, obs_unstable); end
    total++; if ({obs_be, obs_wd} !== {4'b1100, 32'hBEEF_BEEF} || obs_after !== 3'b000) begin bad++;
      $display("FAIL sh_bus got be=%b wd=%h after=%b exp 1100 beefbeef 000", obs_be, obs_wd, obs_after); end
  endtask

  task automatic test_load();
    run_access(0, 1, 3'b000, 32'h0000_0102, 0, 0, 1, 32'h1280_FF00);
    total++; if (obs_stall_n !== 3 || obs_rd_n !== 1 || obs_hung !== 0) begin bad++;
      $display("FAIL lb_timing got stall=%0d rd=%0d hung=%0d exp 3 1 0", obs_stall_n, obs_rd_n, obs_hung); end
    total++; if (obs_rdata !== 32'hFFFF_FF80 || {obs_addr, obs_be} !== {32'h0000_0100, 4'b0100}) begin bad++;
      $display("FAIL lb_data got rdata=%h addr=%h be=%b exp ffffff80 00000100 0100", obs_rdata, obs_addr, obs_be); end

    run_access(0, 1, 3'b100, 32'h0000_0102, 0, 0, 1, 32'h1280_FF00);
    total++; if (obs_rdata !== 32'h0000_0080) begin bad++;
      $display("FAIL lbu_data got=%h exp=00000080", obs_rdata); end

    run_access(0, 1, 3'b001, 32'h0000_0102, 0, 0, 1, 32'h8001_1234);
    total++; if (obs_rdata !== 32'hFFFF_8001 || obs_be !== 4'b1100) begin bad++;
      $display("FAIL lh_data got rdata=%h be=%b exp ffff8001 1100", obs_rdata, obs_be); end

    run_access(0, 1, 3'b101, 32'h0000_0102, 0, 0, 1, 32'h8001_1234);
    total++; if (obs_rdata !== 32'h0000_8001) begin bad++;
      $display("FAIL lhu_data got=%h exp=00008001", obs_rdata); end

    run_access(0, 1, 3'b010, 32'h0000_0104, 0, 2, 3, 32'hCAFE_F00D);
    total++; if (obs_stall_n !== 7 || obs_rd_n !== 3 || obs_rdata !== 32'hCAFE_F00D) begin bad++;
      $display("FAIL lw_wait got stall=%0d rd=%0d rdata=%h exp 7 3 cafef00d", obs_stall_n, obs_rd_n, obs_rdata); end
    model_rdata = 32'hCAFE_F00D;
  endtask

  task automatic test_misalign();
    run_access(0, 1, 3'b010, 32'h0000_0101, 0, 0, 1, 32'h5555_5555);
    total++; if (obs_stall_n !== 1 || obs_rd_n !== 0 || obs_wr_n !== 0) begin bad++;
      $display("FAIL lw_mis_timing got stall=%0d rd=%0d wr=%0d exp 1 0 0", obs_stall_n, obs_rd_n, obs_wr_n); end
    total++; if (obs_misalign !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin bad++;
      $display("FAIL lw_mis_done got mis=%b err=%b rdata=%h exp 1 0 00000000", obs_misalign, obs_err, obs_rdata); end
    total++; if (obs_after !== 3'b000) begin bad++;
      $display("FAIL lw_mis_pulse got after=%b exp 000", obs_after); end

    run_access(0, 1, 3'b010, 32'h0000_010C, 0, 0, 1, 32'h1357_2468);
    run_access(1, 0, 3'b001, 32'h0000_0201, 32'hFFFF_FFFF, 0, 1, 0);
    total++; if (obs_misalign !== 1'b1 || obs_wr_n !== 0 || obs_rdata !== 32'h1357_2468) begin bad++;
      $display("FAIL sh_mis got mis=%b wr=%0d rdata=%h exp 1 0 13572468", obs_misalign, obs_wr_n, obs_rdata); end
    model_rdata = 32'h1357_2468;
  endtask

  task automatic test_timeout();
    run_access(1, 0, 3'b010, 32'h0000_0300, 32'h0BAD_0BAD, 100, 1, 0);
    total++; if (obs_wr_n !== TMO || obs_stall_n !== TMO + 1 || obs_err !== 1'b1) begin bad++;
      $display("FAIL sw_tmo got wr=%0d stall=%0d err=%b exp %0d %0d 1", obs_wr_n, obs_stall_n, obs_err, TMO, TMO + 1); end
    total++; if (obs_rdata !== model_rdata || obs_done_bus !== 1'b0 || obs_after !== 3'b000) begin bad++;
      $display("FAIL sw_tmo_done got rdata=%h bus=%b after=%b exp %h 0 000", obs_rdata, obs_done_bus, obs_after, model_rdata); end

    run_access(1, 0, 3'b010, 32'h0000_0304, 32'h0000_0001, TMO - 2, 1, 0);
    total++; if (obs_wr_n !== TMO - 1 || obs_err !== 1'b0) begin bad++;
      $display("FAIL sw_near_tmo got wr=%0d err=%b exp %0d 0", obs_wr_n, obs_err, TMO - 1); end

    run_access(0, 1, 3'b010, 32'h0000_0300, 0, 100, 1, 32'h7777_7777);
    total++; if (obs_rd_n !== TMO || obs_stall_n !== TMO + 1 || obs_err !== 1'b1) begin bad++;
      $display("FAIL lw_tmo got rd=%0d stall=%0d err=%b exp %0d %0d 1", obs_rd_n, obs_stall_n, obs_err, TMO, TMO + 1); end
    total++; if (obs_rdata !== 32'h0 || obs_misalign !== 1'b0 || obs_after !== 3'b000) begin bad++;
      $display("FAIL lw_tmo_done got rdata=%h mis=%b after=%b exp 00000000 0 000", obs_rdata, obs_misalign, obs_after); end
    model_rdata = '0;
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    run_access(0, 1, 3'b010, 32'h0000_040C, 0, 0, 1, 32'h0BAD_CAFE);
    total++; if (obs_rdata !== 32'h0BAD_CAFE) begin bad++;
      $display("FAIL pre_reset_load got=%h exp=0badcafe", obs_rdata); end
    @(negedge clk);
    req_read = 1'b1; req_type = 3'b010; req_addr = 32'h0000_0400;
    bus_waitrequest = 1'b0; bus_readdatavalid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (bus_read === 1'b1) seen = 1;
      @(negedge clk);
    end
    #1;
    total++; if (seen !== 1 || stall !== 1'b1 || bus_read !== 1'b0) begin bad++;
      $display("FAIL rd_wait_reached got seen=%0d stall=%b rd=%b exp 1 1 0", seen, stall, bus_read); end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({stall, bus_read, bus_write, misalign, bus_err, bus_byteenable,
         bus_addr, bus_writedata, rdata} !== '0) begin
      bad++;
      $display("FAIL mid_reset got stall=%b rd=%b be=%h addr=%h rdata=%h exp all 0",
               stall, bus_read, bus_byteenable, bus_addr, rdata);
    end
    req_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_readdatavalid = 1'b1; bus_readdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      total++; if (rdata !== 32'h0 || stall !== 1'b0 || bus_read !== 1'b0) begin bad++;
        $display("FAIL late_rdv got rdata=%h stall=%b rd=%b exp 00000000 0 0", rdata, stall, bus_read); end
    end
    bus_readdatavalid = 1'b0;
    model_rdata = '0;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  types [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [2:0]  t;
    logic [31:0] a, wd, word;
    bit          wr, rd, mis;
    int          sz, wt, rdv, exp_stall;
    for (int n = 0; n < 40; n++) begin
      wr   = ($urandom_range(0, 1) == 1);
      rd   = wr ? ($urandom_range(0, 2) == 0) : 1'b1;
      t    = types[$urandom_range(0, 7)];
      sz   = ref_size(t);
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      wd   = $urandom;
      word = $urandom;
      wt   = $urandom_range(0, 3);
      rdv  = $urandom_range(1, 3);
      mis  = ref_misal(t, a);
      exp_stall = mis ? 1 : (wr ? 2 + wt : 2 + wt + rdv);
      run_access(wr, rd, t, a, wd, wt, rdv, word);
      if (!wr) model_rdata = mis ? 32'h0 : ref_load(t, a, word);
      total++; if (obs_hung !== 0 || obs_stall_n !== exp_stall) begin bad++;
        $display("FAIL rnd_stall n=%0d got=%0d hung=%0d exp=%0d", n, obs_stall_n, obs_hung, exp_stall); end
      total++; if (obs_misalign !== mis || obs_err !== 1'b0 || obs_after !== 3'b000) begin bad++;
        $display("FAIL rnd_flags n=%0d got mis=%b err=%b after=%b exp %b 0 000", n, obs_misalign, obs_err, obs_after, mis); end
      total++; if (obs_rdata !== model_rdata) begin bad++;
        $display("FAIL rnd_rdata n=%0d t=%b a=%h word=%h got=%h exp=%h", n, t, a, word, obs_rdata, model_rdata); end
      if (!mis) begin
        total++; if (obs_wr_n !== (wr ? wt + 1 : 0) || obs_rd_n !== (wr ? 0 : wt + 1) || obs_unstable !== 0) begin bad++;
          $display("FAIL rnd_cycles n=%0d got wr=%0d rd=%0d unstable=%0d", n, obs_wr_n, obs_rd_n, obs_unstable); end
        total++; if (obs_addr !== {a[31:2], 2'b00} || obs_be !== ref_be(t, a)) begin bad++;
          $display("FAIL rnd_addr_be n=%0d got addr=%h be=%b exp %h %b", n, obs_addr, obs_be, {a[31:2], 2'b00}, ref_be(t, a)); end
        if (wr) begin
          total++; if (obs_wd !== ref_wd(t, wd)) begin bad++;
            $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, obs_wd, ref_wd(t, wd)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
